// File: rtl/serdesphy_link_ctrl.sv
// serdesphy_link_ctrl: SerDes PHY link bring-up sequencer (PLL, CDR, PRBS training, retry, fault latch)
// Ports: clk_ref_24m/rst clock and sync reset; phy_en, power_good, pll_lock, cdr_lock, rx_aligned,
// prbs_err, retrain_req status inputs; PLL/CDR/TX/RX control outputs; phy_ready, link_error,
// link_state, retry_cnt status outputs.
module serdesphy_link_ctrl #(
  parameter int SETTLE_CYC  = 16,
  parameter int PLL_TIMEOUT = 4800,
  parameter int CDR_TIMEOUT = 2400,
  parameter int TRAIN_CYC   = 256,
  parameter int MAX_RETRIES = 3,
  parameter int TMR_W       = 16
) (
  input  logic       clk_ref_24m,
  input  logic       rst,
  input  logic       phy_en,
  input  logic       power_good,
  input  logic       pll_lock,
  input  logic       cdr_lock,
  input  logic       rx_aligned,
  input  logic       prbs_err,
  input  logic       retrain_req,
  output logic       pll_enable,
  output logic       pll_rst,
  output logic       cdr_rst,
  output logic       cdr_fast_lock,
  output logic       tx_en,
  output logic       rx_en,
  output logic       tx_prbs_en,
  output logic       rx_prbs_chk_en,
  output logic       rx_align_rst,
  output logic       phy_ready,
  output logic       link_error,
  output logic [2:0] link_state,
  output logic [3:0] retry_cnt
);
  localparam logic [2:0] IDLE = 3'd0, PLL_RST = 3'd1, PLL_WAIT = 3'd2, CDR_WAIT = 3'd3,
                         TRAIN = 3'd4, ACTIVE = 3'd5, FAIL = 3'd6;
  localparam logic [TMR_W-1:0] SETTLE_T = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] PLL_T    = TMR_W'(PLL_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] CDR_T    = TMR_W'(CDR_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TRAIN_T  = TMR_W'(TRAIN_CYC - 1);
  localparam logic [3:0]       MAX_R    = 4'(MAX_RETRIES);
  localparam logic [10:0]      OUT_IDLE = 11'b01100000000;
  logic [2:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [3:0]       retry_q, retry_d;
  logic [10:0]      out_q, out_d;
  logic             up, lost, retry;
  assign up   = phy_en & power_good;
  assign lost = ~pll_lock | ~cdr_lock | ~rx_aligned;
  always_ff @(posedge clk_ref_24m) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      retry_q <= '0;
      out_q   <= OUT_IDLE;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      out_q   <= out_d;
    end
  end
  // retry is a decision taken on the way out of a state, never a state of its own
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    retry   = 1'b0;
    case (state_q)
      IDLE:     state_d = up ? PLL_RST : IDLE;
      PLL_RST:  state_d = (timer_q == SETTLE_T) ? PLL_WAIT : PLL_RST;
      PLL_WAIT: begin
        state_d = pll_lock ? CDR_WAIT : PLL_WAIT;
        retry   = ~pll_lock & (timer_q == PLL_T);
      end
      CDR_WAIT: begin
        state_d = (pll_lock & cdr_lock & rx_aligned) ? TRAIN : CDR_WAIT;
        retry   = ~pll_lock | (~(cdr_lock & rx_aligned) & (timer_q == CDR_T));
      end
      TRAIN: begin
        retry = prbs_err | lost;
        if (!retry && timer_q == TRAIN_T) begin
          state_d = ACTIVE;
          retry_d = '0;
        end
      end
      ACTIVE: begin
        retry   = lost;
        state_d = retrain_req ? PLL_RST : ACTIVE;
      end
      FAIL:     state_d = FAIL;
      default:  state_d = IDLE;
    endcase
    if (retry) begin
      state_d = (retry_q == MAX_R) ? FAIL : PLL_RST;
      retry_d = (retry_q == MAX_R) ? retry_q : retry_q + 4'd1;
    end
    if (!up) begin
      state_d = IDLE;
      retry_d = '0;
    end
  end
  assign timer_d = (state_d != state_q) ? '0 : (&timer_q) ? timer_q : timer_q + TMR_W'(1);
  // outputs are decoded from the next state so they line up with state_q once registered
  always_comb begin
    case (state_d)
      PLL_RST:  out_d = 11'b11100000000;
      PLL_WAIT: out_d = 11'b10100000000;
      CDR_WAIT: out_d = {8'b10011110, state_q != CDR_WAIT, 2'b00};
      TRAIN:    out_d = 11'b10001111000;
      ACTIVE:   out_d = 11'b10001100010;
      FAIL:     out_d = 11'b01100000001;
      default:  out_d = OUT_IDLE;
    endcase
  end
  assign {pll_enable, pll_rst, cdr_rst, cdr_fast_lock, tx_en, rx_en, tx_prbs_en,
          rx_prbs_chk_en, rx_align_rst, phy_ready, link_error} = out_q;
  assign link_state = state_q;
  assign retry_cnt  = retry_q;
endmodule

// File: tb/tb_serdesphy_link_ctrl.sv
// tb_serdesphy_link_ctrl: directed scoreboard bench for the link bring-up sequencer
module tb_serdesphy_link_ctrl;
  logic clk = 0, rst = 1;
  logic phy_en = 0, power_good = 0, pll_lock = 0, cdr_lock = 0, rx_aligned = 0, prbs_err = 0, retrain_req = 0;
  logic pll_enable, pll_rst, cdr_rst, cdr_fast_lock, tx_en, rx_en, tx_prbs_en, rx_prbs_chk_en;
  logic rx_align_rst, phy_ready, link_error;
  logic [2:0] link_state;
  logic [3:0] retry_cnt;
  serdesphy_link_ctrl #(.SETTLE_CYC(4), .PLL_TIMEOUT(20), .CDR_TIMEOUT(10), .TRAIN_CYC(8),
                        .MAX_RETRIES(2), .TMR_W(16)) dut (
    .clk_ref_24m(clk), .rst(rst), .phy_en(phy_en), .power_good(power_good), .pll_lock(pll_lock),
    .cdr_lock(cdr_lock), .rx_aligned(rx_aligned), .prbs_err(prbs_err), .retrain_req(retrain_req),
    .pll_enable(pll_enable), .pll_rst(pll_rst), .cdr_rst(cdr_rst), .cdr_fast_lock(cdr_fast_lock),
    .tx_en(tx_en), .rx_en(rx_en), .tx_prbs_en(tx_prbs_en), .rx_prbs_chk_en(rx_prbs_chk_en),
    .rx_align_rst(rx_align_rst), .phy_ready(phy_ready), .link_error(link_error),
    .link_state(link_state), .retry_cnt(retry_cnt));
  always #5 clk = ~clk;
  typedef struct {
    string       name;
    int          cyc;
    logic [17:0] val;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int cyc = 0, vectors = 0, miscompares = 0;
  logic [2:0] prev_st = 3'd0;
  logic [17:0] got;
  always @(posedge clk) cyc <= cyc + 1;
  assign got = {link_state, retry_cnt, pll_enable, pll_rst, cdr_rst, cdr_fast_lock, tx_en, rx_en,
                tx_prbs_en, rx_prbs_chk_en, rx_align_rst, phy_ready, link_error};
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      vectors++;
      if (e.cyc != cyc || got !== e.val) begin
        miscompares++;
        $display("FAIL %s cyc=%0d state/retry/outs got=%b exp=%b", e.name, e.cyc, got, e.val);
      end
    end
  end
  // hand table of the outputs each state must show: {pll_en,pll_rst,cdr_rst,fast,tx,rx,tx_prbs,rx_chk,align,ready,err}
  function automatic logic [10:0] exp_out(input logic [2:0] st, input logic al);
    case (st)
      3'd1:    return 11'b11100000000;
      3'd2:    return 11'b10100000000;
      3'd3:    return {8'b10011110, al, 2'b00};
      3'd4:    return 11'b10001111000;
      3'd5:    return 11'b10001100010;
      3'd6:    return 11'b01100000001;
      default: return 11'b01100000000;
    endcase
  endfunction
  task automatic run(input int n, input string name, input logic [2:0] st, input logic [3:0] rc);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      q.push_back('{name, cyc, {st, rc, exp_out(st, st == 3'd3 && prev_st != 3'd3)}});
      prev_st = st;
    end
  endtask
  initial begin
    run(2, "reset", 0, 0);
    rst = 0; phy_en = 1; power_good = 1;
    run(4, "nom_pllrst", 1, 0);
    run(5, "nom_pllwait", 2, 0);
    pll_lock = 1;
    run(3, "nom_cdrwait", 3, 0);
    cdr_lock = 1; rx_aligned = 1;
    run(8, "nom_train", 4, 0);
    run(2, "nom_active", 5, 0);
    cdr_lock = 0;
    run(1, "loss_cdr", 1, 1);
    cdr_lock = 1;
    run(3, "loss_pllrst", 1, 1);
    run(1, "loss_pllwait", 2, 1);
    run(1, "loss_cdrwait", 3, 1);
    run(8, "loss_train", 4, 1);
    run(1, "loss_active", 5, 0);
    retrain_req = 1;
    run(1, "retrain", 1, 0);
    retrain_req = 0;
    run(3, "rt_pllrst", 1, 0);
    run(1, "rt_pllwait", 2, 0);
    run(1, "rt_cdrwait", 3, 0);
    run(8, "rt_train", 4, 0);
    run(1, "rt_active", 5, 0);
    retrain_req = 1; rx_aligned = 0;
    run(1, "loss_wins", 1, 1);
    retrain_req = 0; rx_aligned = 1;
    run(3, "lw_pllrst", 1, 1);
    run(1, "lw_pllwait", 2, 1);
    run(1, "lw_cdrwait", 3, 1);
    run(8, "lw_train", 4, 1);
    run(1, "lw_active", 5, 0);
    retrain_req = 1;
    run(1, "pr_retrain", 1, 0);
    retrain_req = 0;
    run(3, "pr_pllrst", 1, 0);
    run(1, "pr_pllwait", 2, 0);
    run(1, "pr_cdrwait", 3, 0);
    run(5, "pr_train", 4, 0);
    prbs_err = 1;
    run(1, "prbs_err", 1, 1);
    prbs_err = 0;
    run(3, "pr2_pllrst", 1, 1);
    run(1, "pr2_pllwait", 2, 1);
    run(1, "pr2_cdrwait", 3, 1);
    run(8, "pr2_train", 4, 1);
    run(1, "pr2_active", 5, 0);
    retrain_req = 1;
    run(1, "pg_retrain", 1, 0);
    retrain_req = 0; cdr_lock = 0;
    run(3, "pg_pllrst", 1, 0);
    run(1, "pg_pllwait", 2, 0);
    run(3, "pg_cdrwait", 3, 0);
    power_good = 0;
    run(1, "pg_low_idle", 0, 0);
    power_good = 1; cdr_lock = 1;
    run(4, "rs_pllrst", 1, 0);
    run(1, "rs_pllwait", 2, 0);
    run(1, "rs_cdrwait", 3, 0);
    run(3, "rs_train", 4, 0);
    rst = 1;
    run(1, "rst_in_train", 0, 0);
    rst = 0; pll_lock = 0;
    run(4, "to_pllrst0", 1, 0);
    run(20, "to_pllwait0", 2, 0);
    run(1, "to_retry1", 1, 1);
    run(3, "to_pllrst1", 1, 1);
    run(20, "to_pllwait1", 2, 1);
    run(1, "to_retry2", 1, 2);
    run(3, "to_pllrst2", 1, 2);
    run(20, "to_pllwait2", 2, 2);
    run(1, "to_fail", 6, 2);
    retrain_req = 1;
    run(1, "fail_ign_retrain", 6, 2);
    retrain_req = 0;
    run(2, "fail_hold", 6, 2);
    phy_en = 0;
    run(2, "fail_clear", 0, 0);
    phy_en = 1; pll_lock = 1; cdr_lock = 0;
    run(4, "cto_pllrst", 1, 0);
    run(1, "cto_pllwait", 2, 0);
    run(10, "cto_cdrwait", 3, 0);
    run(1, "cto_retry", 1, 1);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain left=%0d required=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
